// File: rtl/seq_div40by8_pkg.sv
// Shared widths, state encoding and counter sizing for the sequential 40/8 divider.
// Imported by the bus interface, the step datapath and the top-level FSM.
package div_pkg;

  localparam int DVD_W = 40;
  localparam int DVS_W = 8;
  localparam int QUO_W = DVD_W - DVS_W;
  localparam int CNT_W = $clog2(QUO_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_div40by8_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
// The requester drives through master; the divider sits on slave.
interface seq_div40by8_if;
  import div_pkg::*;

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [QUO_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_div40by8_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational.
module div_step
  import div_pkg::*;
(
  input  logic [DVS_W-1:0] r_in,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] dvs,
  output logic [DVS_W-1:0] r_out,
  output logic             q_bit
);

  logic [DVS_W:0] t;
  logic [DVS_W:0] dvs_ext;

  assign t       = {r_in, bit_in};
  assign dvs_ext = {1'b0, dvs};
  assign q_bit   = (t >= dvs_ext);
  // With r_in < dvs the difference always fits back into DVS_W bits.
  assign r_out   = q_bit ? DVS_W'(t - dvs_ext) : t[DVS_W-1:0];

endmodule

// File: rtl/seq_div40by8.sv
// Sequential restoring divider, one quotient bit per clock: 34 edges from accept
// to done (2 on divide-by-zero/overflow). start is ignored while busy; no queuing.
module seq_div40by8
  import div_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  seq_div40by8_if.slave  bus
);

  div_state_t       state_q, state_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W-1:0] r_q, r_d;
  logic [QUO_W-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QUO_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [DVS_W-1:0] step_r;
  logic             step_bit;

  div_step u_step (
    .r_in   (r_q),
    .bit_in (q_q[QUO_W-1]),
    .dvs    (dvs_q),
    .r_out  (step_r),
    .q_bit  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      // FIN shares IDLE's accept path so back-to-back requests need no gap.
      IDLE, FIN: begin
        if (bus.start) begin
          state_d = CHECK;
          dvs_d   = bus.divisor;
          r_d     = bus.dividend[DVD_W-1:QUO_W];
          q_d     = bus.dividend[QUO_W-1:0];
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      CHECK: begin
        if (dvs_q == '0) begin
          state_d = FIN;
          quo_d   = '1;
          rem_d   = '0;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
        end else if (r_q >= dvs_q) begin
          // Upper dividend byte already >= divisor: quotient needs more than QUO_W bits.
          state_d = FIN;
          quo_d   = '1;
          rem_d   = '0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        r_d   = step_r;
        q_d   = {q_q[QUO_W-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(QUO_W - 1)) begin
          state_d = FIN;
          quo_d   = {q_q[QUO_W-2:0], step_bit};
          rem_d   = step_r;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvs_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy        = (state_q == CHECK) || (state_q == RUN);
  assign bus.done        = (state_q == FIN);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div40by8.sv
// Scoreboard bench for seq_div40by8: stimulus pushes expected results, a monitor
// pops and compares on every done pulse, including done timing relative to accept.
module tb_seq_div40by8;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  seq_div40by8_if bus ();

  seq_div40by8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] dvd;
    logic [7:0]  dvs;
    logic [31:0] q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
    bit          contract;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        logic [47:0] p;
        e = sb.pop_front();
        chk({e.name, "_quotient"}, bus.quotient, e.q);
        chk({e.name, "_remainder"}, bus.remainder, e.r);
        chk({e.name, "_div_by_zero"}, bus.div_by_zero, e.dbz);
        chk({e.name, "_overflow"}, bus.overflow, e.ovf);
        chk({e.name, "_busy_at_done"}, bus.busy, 0);
        chk({e.name, "_latency"}, cyc - e.acc, e.lat);
        if (e.contract) begin
          p = 48'(bus.quotient) * 48'(e.dvs) + 48'(bus.remainder);
          chk({e.name, "_contract"}, p, e.dvd);
          chk({e.name, "_rem_lt_dvs"}, bus.remainder < e.dvs, 1);
        end
      end
    end
  end

  // Called at a negedge; waits for busy low, drives one accepted start, returns at the next negedge.
  task automatic issue(input logic [39:0] dvd, input logic [7:0] dvs,
                       input logic [31:0] q, input logic [7:0] r,
                       input logic dbz, input logic ovf, input bit push,
                       input bit contract, input string name);
    exp_t e;
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({name, "_wait_idle_timeout"}, 1, 0);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    e.dvd = dvd; e.dvs = dvs; e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
    e.lat = (dbz || ovf) ? 1 : 33;
    e.acc = cyc + 1;
    e.contract = contract;
    e.name = name;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_flags", {bus.div_by_zero, bus.overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(40'd1000000, 8'd7, 32'd142857, 8'd1, 0, 0, 1, 0, "d1000000_7");
    issue(40'hFE_FFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 8'hFE, 0, 0, 1, 0, "max_ff");
    issue(40'h05_0000_0000, 8'd5, 32'hFFFF_FFFF, 8'd0, 0, 1, 1, 0, "ovf");
    issue(40'd123, 8'd0, 32'hFFFF_FFFF, 8'd0, 1, 0, 1, 0, "dbz");

    // Ignored start mid-run, then accepted start in the FIN cycle.
    issue(40'd100, 8'd3, 32'd33, 8'd1, 0, 0, 1, 0, "d100_3");
    repeat (11) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 40'd9; bus.divisor = 8'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    begin
      int n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("fin_wait_timeout", n >= 100, 0);
    end
    issue(40'd9, 8'd2, 32'd4, 8'd1, 0, 0, 1, 0, "d9_2_fin");

    // Reset mid-run: outputs clear at once and the aborted op never completes.
    issue(40'd1000, 8'd9, 32'd111, 8'd1, 0, 0, 0, 0, "abort");
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_flags", {bus.div_by_zero, bus.overflow}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(40'd1000, 8'd9, 32'd111, 8'd1, 0, 0, 1, 0, "d1000_9");

    for (int i = 0; i < 1500; i++) begin
      logic [7:0]  d;
      logic [7:0]  hi;
      logic [39:0] dvd;
      logic [39:0] qq;
      logic [39:0] rr;
      d   = 8'($urandom_range(1, 255));
      hi  = 8'($urandom_range(0, int'(d) - 1));
      dvd = {hi, 32'($urandom)};
      qq  = dvd / {32'd0, d};
      rr  = dvd % {32'd0, d};
      issue(dvd, d, qq[31:0], rr[7:0], 0, 0, 1, 1, "rand");
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("drain_outstanding", sb.size(), 0);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
